// File: rtl/zion_riscv_isa_lib_bits_op_decoder_if.sv
// -----------------------------------------------------------------------------
// zion_riscv_isa_lib_bits_op_decoder_if
//
// Purpose:
//   Groups the upstream (decode) handshake, the raw instruction/operand beat
//   and the downstream (bit-op executor) bundle of the bit-op decoder into one
//   interface. clk and rst are plain ports on the modules.
//
// Signals:
//   iFlush                 synchronous pipeline flush
//   iDeValid / oDeReady    upstream valid / registered ready
//   iInst                  raw 32-bit instruction
//   iRs1Data / iRs2Data    register operands, CPU_WIDTH bits
//   oExValid / iExReady    downstream valid / ready
//   oAndEn/oOrEn/oXorEn    operation selects (at most one set)
//   oS1 / oS2              executor operands
//   oRd                    destination register index
//   oBitOp                 beat holds a recognised bit-op/LUI
//
// Modports:
//   slave  - the decoder itself (consumes the instruction, drives the bundle)
//   master - the surrounding pipeline or testbench
// -----------------------------------------------------------------------------
interface zion_riscv_isa_lib_bits_op_decoder_if #(
    parameter int RV64 = 0
);
    localparam int CPU_WIDTH = 32 * (RV64 + 1);

    logic                 iFlush;
    logic                 iDeValid;
    logic                 oDeReady;
    logic [31:0]          iInst;
    logic [CPU_WIDTH-1:0] iRs1Data;
    logic [CPU_WIDTH-1:0] iRs2Data;
    logic                 oExValid;
    logic                 iExReady;
    logic                 oAndEn;
    logic                 oOrEn;
    logic                 oXorEn;
    logic [CPU_WIDTH-1:0] oS1;
    logic [CPU_WIDTH-1:0] oS2;
    logic [4:0]           oRd;
    logic                 oBitOp;

    modport slave (
        input  iFlush, iDeValid, iInst, iRs1Data, iRs2Data, iExReady,
        output oDeReady, oExValid, oAndEn, oOrEn, oXorEn, oS1, oS2, oRd, oBitOp
    );

    modport master (
        output iFlush, iDeValid, iInst, iRs1Data, iRs2Data, iExReady,
        input  oDeReady, oExValid, oAndEn, oOrEn, oXorEn, oS1, oS2, oRd, oBitOp
    );
endinterface

// File: rtl/zion_riscv_isa_lib_bits_op_decoder.sv
// -----------------------------------------------------------------------------
// zion_riscv_isa_lib_bits_op_decoder
//
// Purpose:
//   Decode-side producer for the bit-operation executor. Each accepted beat
//   (instruction + rs1/rs2 values) is decoded into andEn/orEn/xorEn and the two
//   operands s1/s2 for AND/OR/XOR, ANDI/ORI/XORI and LUI. Any other instruction
//   still produces a beat (all selects and operands zero, oBitOp=0) so slot
//   ordering downstream is preserved and the executor returns 0.
//
//   A 2-entry buffer (output register + skid entry) gives valid/ready
//   backpressure with a registered upstream ready: oDeReady is simply "skid
//   entry empty". Latency is one cycle, throughput one beat per cycle.
//
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset
//   bus   zion_riscv_isa_lib_bits_op_decoder_if.slave (handshakes, beat,
//         executor bundle, flush)
//
// Parameters:
//   RV64  1 = 64-bit datapath, 0 = 32-bit; must match the interface instance
// -----------------------------------------------------------------------------
module zion_riscv_isa_lib_bits_op_decoder #(
    parameter int RV64 = 0
) (
    input  logic clk,
    input  logic rst,
    zion_riscv_isa_lib_bits_op_decoder_if.slave bus
);
    localparam int CPU_WIDTH = 32 * (RV64 + 1);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_XOR = 3'b100;

    // One decoded beat, as held in either buffer entry.
    typedef struct packed {
        logic                 and_en;
        logic                 or_en;
        logic                 xor_en;
        logic                 bit_op;
        logic [4:0]           rd;
        logic [CPU_WIDTH-1:0] s1;
        logic [CPU_WIDTH-1:0] s2;
    } beat_t;

    // -------------------------------------------------------------------------
    // Combinational decode of the incoming beat
    // -------------------------------------------------------------------------
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic                 f3_is_logic;
    logic [CPU_WIDTH-1:0] imm_i;
    logic [CPU_WIDTH-1:0] imm_u;
    logic [31:0]          imm_u32;
    beat_t                dec;

    assign opcode  = bus.iInst[6:0];
    assign funct3  = bus.iInst[14:12];
    assign funct7  = bus.iInst[31:25];
    assign imm_u32 = {bus.iInst[31:12], 12'b0};

    // Signed casts sign-extend to the datapath width for both RV32 and RV64.
    assign imm_i = CPU_WIDTH'(signed'(bus.iInst[31:20]));
    assign imm_u = CPU_WIDTH'(signed'(imm_u32));

    assign f3_is_logic = (funct3 == F3_AND) || (funct3 == F3_OR) || (funct3 == F3_XOR);

    always_comb begin
        // NOTE: every field gets a default before the case so no path can
        // leave a signal unassigned and infer a latch.
        dec    = '0;
        dec.rd = bus.iInst[11:7];
        case (opcode)
            OPC_OP: begin
                // Only funct7=0 is a logic op; 0100000 with funct3=110 is not OR.
                if ((funct7 == 7'b0000000) && f3_is_logic) begin
                    dec.bit_op = 1'b1;
                    dec.and_en = (funct3 == F3_AND);
                    dec.or_en  = (funct3 == F3_OR);
                    dec.xor_en = (funct3 == F3_XOR);
                    dec.s1     = bus.iRs1Data;
                    dec.s2     = bus.iRs2Data;
                end
            end
            OPC_OP_IMM: begin
                if (f3_is_logic) begin
                    dec.bit_op = 1'b1;
                    dec.and_en = (funct3 == F3_AND);
                    dec.or_en  = (funct3 == F3_OR);
                    dec.xor_en = (funct3 == F3_XOR);
                    dec.s1     = bus.iRs1Data;
                    dec.s2     = imm_i;
                end
            end
            OPC_LUI: begin
                // LUI is executed as 0 | imm.
                dec.bit_op = 1'b1;
                dec.or_en  = 1'b1;
                dec.s2     = imm_u;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Two-entry skid buffer
    // -------------------------------------------------------------------------
    beat_t out_q,      out_d;
    beat_t skid_q,     skid_d;
    logic  out_vld_q,  out_vld_d;
    logic  skid_vld_q, skid_vld_d;
    logic  de_ready_q, de_ready_d;

    logic  in_fire;
    logic  out_fire;
    logic  out_free;

    assign in_fire  = bus.iDeValid && de_ready_q;
    assign out_fire = out_vld_q && bus.iExReady;
    // Output register may take a new beat this edge.
    assign out_free = !out_vld_q || out_fire;

    always_comb begin
        out_d      = out_q;
        skid_d     = skid_q;
        out_vld_d  = out_vld_q;
        skid_vld_d = skid_vld_q;

        if (bus.iFlush) begin
            // Flush wins over any input transfer; a coincident output
            // transfer has already completed on the wire and is not undone.
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
            out_d      = '0;
            skid_d     = '0;
        end else if (out_free) begin
            if (skid_vld_q) begin
                // Skid entry drains first to keep order. Upstream ready is
                // low while it is full, so no input can arrive this cycle.
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else if (in_fire) begin
                out_d     = dec;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (in_fire) begin
            // Output stalled: park the accepted beat in the skid entry.
            skid_d     = dec;
            skid_vld_d = 1'b1;
        end

        de_ready_d = !skid_vld_d;
    end

    // NOTE: payload registers are reset along with the valids because the
    // bundle must read all-zero during reset, not merely be marked invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            de_ready_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            out_q      <= out_d;
            skid_q     <= skid_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            de_ready_q <= de_ready_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.oDeReady = de_ready_q;
    assign bus.oExValid = out_vld_q;
    assign bus.oAndEn   = out_q.and_en;
    assign bus.oOrEn    = out_q.or_en;
    assign bus.oXorEn   = out_q.xor_en;
    assign bus.oBitOp   = out_q.bit_op;
    assign bus.oRd      = out_q.rd;
    assign bus.oS1      = out_q.s1;
    assign bus.oS2      = out_q.s2;

    // -------------------------------------------------------------------------
    // Protocol checks
    // -------------------------------------------------------------------------
    a_onehot_en : assert property (@(posedge clk) disable iff (rst)
        bus.oExValid |-> $onehot0({bus.oAndEn, bus.oOrEn, bus.oXorEn}));

    a_stall_stable : assert property (@(posedge clk) disable iff (rst)
        (bus.oExValid && !bus.iExReady && !bus.iFlush) |=>
            (bus.oExValid && $stable(out_q)));

endmodule

// File: tb/tb_zion_riscv_isa_lib_bits_op_decoder.sv
// -----------------------------------------------------------------------------
// tb_zion_riscv_isa_lib_bits_op_decoder
//
// Directed bench for the bit-op decoder: an RV32 instance carries the main
// sequence, an RV64 instance covers the wide LUI sign extension. Inputs are
// driven 1 time unit after the rising edge and outputs sampled there too.
// -----------------------------------------------------------------------------
module tb_zion_riscv_isa_lib_bits_op_decoder;

    logic clk;
    logic rst;

    zion_riscv_isa_lib_bits_op_decoder_if #(.RV64(0)) bus32 ();
    zion_riscv_isa_lib_bits_op_decoder_if #(.RV64(1)) bus64 ();

    zion_riscv_isa_lib_bits_op_decoder #(.RV64(0)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32.slave)
    );

    zion_riscv_isa_lib_bits_op_decoder #(.RV64(1)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, 5'd1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction

    // Backpressure beat k: ORI imm=k+1, rs1 = 0x1000_0000 + k.
    task automatic present_bp(input int k);
        bus32.iDeValid = 1'b1;
        bus32.iInst    = enc_i(12'(k + 1), 3'b110, 5'd3);
        bus32.iRs1Data = 32'h1000_0000 + 32'(k);
        bus32.iRs2Data = 32'hDEAD_BEEF;
    endtask

    task automatic present_ori(input logic [11:0] imm, input logic [31:0] rs1);
        bus32.iDeValid = 1'b1;
        bus32.iInst    = enc_i(imm, 3'b110, 5'd4);
        bus32.iRs1Data = rs1;
        bus32.iRs2Data = 32'h0;
    endtask

    int idx;
    int delivered;
    int acc;

    initial begin
        rst            = 1'b1;
        bus32.iFlush   = 1'b0;
        bus32.iDeValid = 1'b0;
        bus32.iInst    = 32'h0;
        bus32.iRs1Data = 32'h0;
        bus32.iRs2Data = 32'h0;
        bus32.iExReady = 1'b0;
        bus64.iFlush   = 1'b0;
        bus64.iDeValid = 1'b0;
        bus64.iInst    = 32'h0;
        bus64.iRs1Data = 64'h0;
        bus64.iRs2Data = 64'h0;
        bus64.iExReady = 1'b1;

        // ---- reset state ----
        #2;
        check("rst_exvalid", 64'(bus32.oExValid), 64'd0);
        check("rst_deready", 64'(bus32.oDeReady), 64'd1);
        check("rst_s2",      64'(bus32.oS2),      64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // ---- AND ----
        bus32.iExReady = 1'b1;
        bus32.iDeValid = 1'b1;
        bus32.iInst    = enc_r(7'b0000000, 3'b111, 5'd5);
        bus32.iRs1Data = 32'hF0F0_00FF;
        bus32.iRs2Data = 32'h0FF0_FF00;
        tick();
        check("and_valid",  64'(bus32.oExValid), 64'd1);
        check("and_en",     64'({bus32.oAndEn, bus32.oOrEn, bus32.oXorEn}), 64'b100);
        check("and_s1",     64'(bus32.oS1), 64'hF0F0_00FF);
        check("and_s2",     64'(bus32.oS2), 64'h0FF0_FF00);
        check("and_bitop",  64'(bus32.oBitOp), 64'd1);
        check("and_rd",     64'(bus32.oRd), 64'd5);
        check("and_result", 64'(bus32.oS1 & bus32.oS2), 64'h00F0_0000);

        // ---- ANDI imm 0x800 ----
        bus32.iInst    = enc_i(12'h800, 3'b111, 5'd6);
        bus32.iRs1Data = 32'h1234_5678;
        tick();
        check("andi_en", 64'({bus32.oAndEn, bus32.oOrEn, bus32.oXorEn}), 64'b100);
        check("andi_s1", 64'(bus32.oS1), 64'h1234_5678);
        check("andi_s2", 64'(bus32.oS2), 64'hFFFF_F800);

        // ---- XORI imm 0x7FF ----
        bus32.iInst = enc_i(12'h7FF, 3'b100, 5'd7);
        tick();
        check("xori_en", 64'({bus32.oAndEn, bus32.oOrEn, bus32.oXorEn}), 64'b001);
        check("xori_s2", 64'(bus32.oS2), 64'h0000_07FF);

        // ---- LUI (RV32 and RV64) ----
        bus32.iInst    = enc_u(20'h12345, 5'd8);
        bus64.iDeValid = 1'b1;
        bus64.iInst    = enc_u(20'h80000, 5'd9);
        bus64.iRs1Data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        bus64.iDeValid = 1'b0;
        check("lui_en",    64'({bus32.oAndEn, bus32.oOrEn, bus32.oXorEn}), 64'b010);
        check("lui_s1",    64'(bus32.oS1), 64'd0);
        check("lui_s2",    64'(bus32.oS2), 64'h1234_5000);
        check("lui64_vld", 64'(bus64.oExValid), 64'd1);
        check("lui64_s1",  bus64.oS1, 64'd0);
        check("lui64_s2",  bus64.oS2, 64'hFFFF_FFFF_8000_0000);
        check("lui64_or",  64'(bus64.oOrEn), 64'd1);

        // ---- non bit-ops: ADD, then SUB-encoded OR ----
        bus32.iInst = enc_r(7'b0000000, 3'b000, 5'd10);
        tick();
        check("add_valid", 64'(bus32.oExValid), 64'd1);
        check("add_bitop", 64'(bus32.oBitOp), 64'd0);
        check("add_en",    64'({bus32.oAndEn, bus32.oOrEn, bus32.oXorEn}), 64'b000);
        check("add_ops",   {bus32.oS1, bus32.oS2}, 64'd0);
        bus32.iInst = enc_r(7'b0100000, 3'b110, 5'd11);
        tick();
        check("subor_valid", 64'(bus32.oExValid), 64'd1);
        check("subor_bitop", 64'(bus32.oBitOp), 64'd0);
        check("subor_en",    64'({bus32.oAndEn, bus32.oOrEn, bus32.oXorEn}), 64'b000);
        check("subor_ops",   {bus32.oS1, bus32.oS2}, 64'd0);

        bus32.iDeValid = 1'b0;
        tick();
        check("idle_valid", 64'(bus32.oExValid), 64'd0);

        // ---- backpressure: 4 beats offered, downstream stalled ----
        bus32.iExReady = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            present_bp(idx);
            acc = int'(bus32.oDeReady);
            tick();
            idx += acc;
            if (c >= 1) begin
                check("bp_deready_low", 64'(bus32.oDeReady), 64'd0);
                check("bp_stable_s1",   64'(bus32.oS1), 64'h1000_0000);
                check("bp_stable_s2",   64'(bus32.oS2), 64'd1);
            end
        end
        check("bp_accepted", 64'(idx), 64'd2);
        check("bp_valid",    64'(bus32.oExValid), 64'd1);

        // Release: upstream keeps offering beat idx until accepted.
        bus32.iExReady = 1'b1;
        delivered = 0;
        for (int c = 0; c < 20 && delivered < 4; c++) begin
            if (idx < 4) present_bp(idx);
            else         bus32.iDeValid = 1'b0;
            acc = int'(bus32.iDeValid && bus32.oDeReady);
            if (bus32.oExValid) begin
                check("bp_order_s1", 64'(bus32.oS1), 64'(32'h1000_0000 + 32'(delivered)));
                check("bp_order_s2", 64'(bus32.oS2), 64'(delivered + 1));
                delivered++;
            end
            tick();
            idx += acc;
        end
        check("bp_delivered", 64'(delivered), 64'd4);
        bus32.iDeValid = 1'b0;
        tick();
        check("bp_drained", 64'(bus32.oExValid), 64'd0);

        // ---- flush with both entries full and input valid ----
        bus32.iExReady = 1'b0;
        present_ori(12'h011, 32'h0000_00AA);
        tick();
        present_ori(12'h022, 32'h0000_00BB);
        tick();
        check("fl_full_ready", 64'(bus32.oDeReady), 64'd0);
        check("fl_full_s1",    64'(bus32.oS1), 64'h0000_00AA);
        bus32.iFlush = 1'b1;
        present_ori(12'h033, 32'h0000_00CC);
        tick();
        bus32.iFlush = 1'b0;
        check("fl_valid",   64'(bus32.oExValid), 64'd0);
        check("fl_deready", 64'(bus32.oDeReady), 64'd1);
        bus32.iExReady = 1'b1;
        present_ori(12'h044, 32'h0000_00DD);
        tick();
        check("fl_next_valid", 64'(bus32.oExValid), 64'd1);
        check("fl_next_s1",    64'(bus32.oS1), 64'h0000_00DD);
        bus32.iDeValid = 1'b0;
        tick();
        check("fl_after_empty", 64'(bus32.oExValid), 64'd0);

        // ---- flush drops an input that would have been accepted ----
        bus32.iExReady = 1'b0;
        present_ori(12'h055, 32'h0000_00EE);
        tick();
        bus32.iFlush = 1'b1;
        present_ori(12'h066, 32'h0000_00FF);
        tick();
        bus32.iFlush   = 1'b0;
        bus32.iDeValid = 1'b0;
        check("fl2_valid",   64'(bus32.oExValid), 64'd0);
        check("fl2_deready", 64'(bus32.oDeReady), 64'd1);
        tick();
        check("fl2_dropped", 64'(bus32.oExValid), 64'd0);

        // ---- asynchronous reset mid-stream ----
        present_ori(12'h077, 32'h0000_0111);
        tick();
        present_ori(12'h088, 32'h0000_0222);
        tick();
        bus32.iDeValid = 1'b0;
        check("ar_pre_ready", 64'(bus32.oDeReady), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid",   64'(bus32.oExValid), 64'd0);
        check("ar_deready", 64'(bus32.oDeReady), 64'd1);
        check("ar_ops",     {bus32.oS1, bus32.oS2}, 64'd0);
        check("ar_flags",   64'({bus32.oAndEn, bus32.oOrEn, bus32.oXorEn, bus32.oBitOp}), 64'd0);
        bus32.iExReady = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("ar_no_stale", 64'(bus32.oExValid), 64'd0);
        bus32.iDeValid = 1'b1;
        bus32.iInst    = enc_r(7'b0000000, 3'b100, 5'd12);
        bus32.iRs1Data = 32'hAAAA_5555;
        bus32.iRs2Data = 32'h0F0F_0F0F;
        tick();
        bus32.iDeValid = 1'b0;
        check("ar_resume_en", 64'({bus32.oAndEn, bus32.oOrEn, bus32.oXorEn}), 64'b001);
        check("ar_resume_s2", 64'(bus32.oS2), 64'h0F0F_0F0F);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
